// File: rtl/biu_pkg.sv
// Shared encodings and widths for the BIU arbiter slice.
// Owner codes double as grant bit positions.
package biu_pkg;

  localparam int ADDR_W = 64;
  localparam int LINE_W = 512;
  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    OWN_IC = 2'd0,
    OWN_DC = 2'd1,
    OWN_MM = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin grant, searching upward from ptr.
// Purely combinational; next_ptr is the slot after the winner.
module rr_arb3
  import biu_pkg::*;
(
  input  logic [2:0] vld,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] next_ptr
);

  logic [1:0] idx;

  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    idx      = (ptr > 2'd2) ? 2'd0 : ptr;
    for (int i = 0; i < 3; i++) begin
      if (gnt == 3'b000 && vld[idx]) begin
        gnt[idx] = 1'b1;
        next_ptr = ptr_inc(idx);
      end
      idx = ptr_inc(idx);
    end
  end

endmodule

// File: rtl/biu_arbiter.sv
// Shares the BIU cache/uncache ports between icache, dcache and LSU.
// One transaction in flight; response is routed back to its owner.
module biu_arbiter #(
  parameter int ADDR_W = biu_pkg::ADDR_W,
  parameter int LINE_W = biu_pkg::LINE_W,
  parameter int WORD_W = biu_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_vld_i,
  output logic              ic_req_rdy_o,
  input  logic [ADDR_W-1:0] ic_req_addr_i,
  output logic              ic_resp_vld_o,
  input  logic              ic_resp_rdy_i,
  output logic [LINE_W-1:0] ic_resp_rdata_o,
  output logic              ic_resp_err_o,
  input  logic              ic_flush_i,
  input  logic              dc_req_vld_i,
  output logic              dc_req_rdy_o,
  input  logic              dc_req_rd_i,
  input  logic [ADDR_W-1:0] dc_req_addr_i,
  input  logic [LINE_W-1:0] dc_req_wdata_i,
  output logic              dc_resp_vld_o,
  input  logic              dc_resp_rdy_i,
  output logic [LINE_W-1:0] dc_resp_rdata_o,
  output logic              dc_resp_err_o,
  input  logic              mm_req_vld_i,
  output logic              mm_req_rdy_o,
  input  logic              mm_req_rd_i,
  input  logic [ADDR_W-1:0] mm_req_addr_i,
  input  logic [WORD_W-1:0] mm_req_wdata_i,
  output logic              mm_resp_vld_o,
  input  logic              mm_resp_rdy_i,
  output logic [WORD_W-1:0] mm_resp_rdata_o,
  output logic              mm_resp_err_o,
  output logic              biu_c_req_vld_o,
  input  logic              biu_c_req_rdy_i,
  output logic              biu_c_req_rd_o,
  output logic [ADDR_W-1:0] biu_c_req_addr_o,
  output logic [LINE_W-1:0] biu_c_req_wdata_o,
  input  logic              biu_c_resp_vld_i,
  output logic              biu_c_resp_rdy_o,
  input  logic [LINE_W-1:0] biu_c_resp_rdata_i,
  input  logic              biu_c_resp_err_i,
  output logic              biu_u_req_vld_o,
  input  logic              biu_u_req_rdy_i,
  output logic              biu_u_req_rd_o,
  output logic [ADDR_W-1:0] biu_u_req_addr_o,
  output logic [WORD_W-1:0] biu_u_req_wdata_o,
  input  logic              biu_u_resp_vld_i,
  output logic              biu_u_resp_rdy_o,
  input  logic [WORD_W-1:0] biu_u_resp_rdata_i,
  input  logic              biu_u_resp_err_i
);

  import biu_pkg::*;

  state_e            state, state_nx;
  owner_e            owner, acc_owner;
  logic              rd, acc_rd, err, drop;
  logic [ADDR_W-1:0] addr, acc_addr;
  logic [LINE_W-1:0] wdata, acc_wdata, rdata;
  logic [1:0]        rr_ptr, next_ptr;
  logic [2:0]        gnt;
  logic              accept, is_ic, is_mm, flush_ic;
  logic              own_req_rdy, own_resp_vld, own_resp_rdy;

  rr_arb3 u_arb (
    .vld      ({mm_req_vld_i, dc_req_vld_i, ic_req_vld_i}),
    .ptr      (rr_ptr),
    .gnt      (gnt),
    .next_ptr (next_ptr)
  );

  assign accept   = (state == ST_IDLE) && (gnt != 3'b000);
  assign is_ic    = (owner == OWN_IC);
  assign is_mm    = (owner == OWN_MM);
  assign flush_ic = ic_flush_i && is_ic;

  assign ic_req_rdy_o = (state == ST_IDLE) && gnt[0];
  assign dc_req_rdy_o = (state == ST_IDLE) && gnt[1];
  assign mm_req_rdy_o = (state == ST_IDLE) && gnt[2];

  assign own_req_rdy  = is_mm ? biu_u_req_rdy_i : biu_c_req_rdy_i;
  assign own_resp_vld = is_mm ? biu_u_resp_vld_i : biu_c_resp_vld_i;
  assign own_resp_rdy = is_ic ? ic_resp_rdy_i :
                        is_mm ? mm_resp_rdy_i : dc_resp_rdy_i;

  assign biu_c_req_vld_o   = (state == ST_ISSUE) && !is_mm;
  assign biu_c_req_rd_o    = rd;
  assign biu_c_req_addr_o  = addr;
  assign biu_c_req_wdata_o = wdata;
  assign biu_c_resp_rdy_o  = (state == ST_WAIT) && !is_mm;

  assign biu_u_req_vld_o   = (state == ST_ISSUE) && is_mm;
  assign biu_u_req_rd_o    = rd;
  assign biu_u_req_addr_o  = addr;
  assign biu_u_req_wdata_o = wdata[WORD_W-1:0];
  assign biu_u_resp_rdy_o  = (state == ST_WAIT) && is_mm;

  assign ic_resp_vld_o   = (state == ST_RESP) && is_ic;
  assign dc_resp_vld_o   = (state == ST_RESP) && (owner == OWN_DC);
  assign mm_resp_vld_o   = (state == ST_RESP) && is_mm;
  assign ic_resp_rdata_o = rdata;
  assign dc_resp_rdata_o = rdata;
  assign mm_resp_rdata_o = rdata[WORD_W-1:0];
  assign ic_resp_err_o   = err;
  assign dc_resp_err_o   = err;
  assign mm_resp_err_o   = err;

  always_comb begin
    acc_owner = OWN_IC;
    acc_rd    = 1'b1;
    acc_addr  = ic_req_addr_i;
    acc_wdata = '0;
    unique case (1'b1)
      gnt[1]: begin
        acc_owner = OWN_DC;
        acc_rd    = dc_req_rd_i;
        acc_addr  = dc_req_addr_i;
        acc_wdata = dc_req_wdata_i;
      end
      gnt[2]: begin
        acc_owner = OWN_MM;
        acc_rd    = mm_req_rd_i;
        acc_addr  = mm_req_addr_i;
        acc_wdata = LINE_W'(mm_req_wdata_i);
      end
      default: ;
    endcase
  end

  // A dropped icache response is still consumed, just never forwarded.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nx = ST_ISSUE;
      ST_ISSUE: if (own_req_rdy) state_nx = ST_WAIT;
      ST_WAIT:
        if (own_resp_vld)
          state_nx = (drop || flush_ic) ? ST_IDLE : ST_RESP;
      ST_RESP:
        if (own_resp_rdy || flush_ic) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      owner  <= OWN_IC;
      rr_ptr <= 2'd0;
      rd     <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      rdata  <= '0;
      err    <= 1'b0;
      drop   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner  <= acc_owner;
        rd     <= acc_rd;
        addr   <= acc_addr;
        wdata  <= acc_wdata;
        rr_ptr <= next_ptr;
      end
      if (state_nx == ST_IDLE)
        drop <= 1'b0;
      else if ((state == ST_ISSUE || state == ST_WAIT) && flush_ic)
        drop <= 1'b1;
      if (state == ST_WAIT && own_resp_vld) begin
        err <= is_mm ? biu_u_resp_err_i : biu_c_resp_err_i;
        if (!rd)
          rdata <= '0;
        else if (is_mm)
          rdata <= LINE_W'(biu_u_resp_rdata_i);
        else
          rdata <= biu_c_resp_rdata_i;
      end
    end
  end

endmodule
